wb_regfile: RTL and testbench

//  Consumer end of the MEM/WB pipeline register: the write-back stage plus the integer register file.

---
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage plus integer register file: selects the ALU or load value, commits it to
// the register array and serves two combinational read ports with same-cycle write-through.
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemtoReg_in,
  input  logic            RegWrite_in,
  input  logic [XLEN-1:0] Result_in,
  input  logic [XLEN-1:0] Read_Data_in,
  input  logic [AW-1:0]   rd_in,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_en,
  output logic [AW-1:0]   wb_rd,
  output logic [CNTW-1:0] wr_count
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [CNTW-1:0] r_wr_count;

  logic [XLEN-1:0] w_wb_data;
  logic            w_wb_en;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;

  // All write-back outputs are forced quiet while reset is held low.
  always_comb begin
    w_wb_data = '0;
    w_wb_en   = 1'b0;
    if (reset) begin
      w_wb_data = MemtoReg_in ? Read_Data_in : Result_in;
      w_wb_en   = RegWrite_in && (rd_in != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wb_en) begin
      r_regs[rd_in] <= w_wb_data;
      r_wr_count    <= r_wr_count + 1'b1;
    end
  end

  // x0 reads zero first, then the committing write bypasses the array.
  always_comb begin
    w_rs1_data = '0;
    if (!reset || rs1 == '0) begin
      w_rs1_data = '0;
    end else if (w_wb_en && rd_in == rs1) begin
      w_rs1_data = w_wb_data;
    end else begin
      w_rs1_data = r_regs[rs1];
    end
  end

  always_comb begin
    w_rs2_data = '0;
    if (!reset || rs2 == '0) begin
      w_rs2_data = '0;
    end else if (w_wb_en && rd_in == rs2) begin
      w_rs2_data = w_wb_data;
    end else begin
      w_rs2_data = r_regs[rs2];
    end
  end

  assign rs1_data = w_rs1_data;
  assign rs2_data = w_rs2_data;
  assign wb_data  = w_wb_data;
  assign wb_en    = w_wb_en;
  assign wb_rd    = reset ? rd_in : '0;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; a second instance with a 4-bit counter exercises counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        MemtoReg_in;
  logic        RegWrite_in;
  logic [63:0] Result_in;
  logic [63:0] Read_Data_in;
  logic [4:0]  rd_in;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic [63:0] wb_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wr_count;

  logic [63:0] s_rs1_data;
  logic [63:0] s_rs2_data;
  logic [63:0] s_wb_data;
  logic        s_wb_en;
  logic [4:0]  s_wb_rd;
  logic [3:0]  s_wr_count;

  int errors;
  int checks;

  wb_regfile dut (
    .clk(clk), .reset(reset), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .Result_in(Result_in), .Read_Data_in(Read_Data_in), .rd_in(rd_in),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_en(wb_en), .wb_rd(wb_rd), .wr_count(wr_count)
  );

  wb_regfile #(.CNTW(4)) dut_small (
    .clk(clk), .reset(reset), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .Result_in(Result_in), .Read_Data_in(Read_Data_in), .rd_in(rd_in),
    .rs1(rs1), .rs2(rs2), .rs1_data(s_rs1_data), .rs2_data(s_rs2_data),
    .wb_data(s_wb_data), .wb_en(s_wb_en), .wb_rd(s_wb_rd), .wr_count(s_wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic mem, input logic we, input logic [63:0] res,
                        input logic [63:0] ldat, input logic [4:0] rd);
    MemtoReg_in  = mem;
    RegWrite_in  = we;
    Result_in    = res;
    Read_Data_in = ldat;
    rd_in        = rd;
  endtask

  task automatic test_reset();
    set_wb(1'b0, 1'b1, 64'h5555, 64'h6666, 5'd5);
    rs1 = 5'd5;
    rs2 = 5'd5;
    repeat (3) step();
    checks++;
    if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got=%0b exp=0", wb_en); end
    checks++;
    if (wb_data !== 64'h0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    checks++;
    if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    checks++;
    if (wr_count !== 32'd0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    checks++;
    if (rs1_data !== 64'h0 || rs2_data !== 64'h0) begin
      errors++; $display("FAIL reset_reads got=%h/%h exp=0/0", rs1_data, rs2_data);
    end
    RegWrite_in = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (rs1_data !== 64'h0) begin errors++; $display("FAIL reset_x5_kept_zero got=%h exp=0", rs1_data); end
  endtask

  task automatic test_write_alu();
    set_wb(1'b0, 1'b1, 64'hDEAD_BEEF, 64'h1111, 5'd3);
    rs1 = 5'd3;
    rs2 = 5'd0;
    #1;
    checks++;
    if (wb_en !== 1'b1 || wb_data !== 64'hDEAD_BEEF || wb_rd !== 5'd3) begin
      errors++; $display("FAIL alu_wb_outputs got en=%0b data=%h rd=%0d exp 1/deadbeef/3", wb_en, wb_data, wb_rd);
    end
    step();
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL alu_readback got=%h exp=deadbeef", rs1_data); end
    checks++;
    if (wr_count !== 32'd1) begin errors++; $display("FAIL alu_wr_count got=%0d exp=1", wr_count); end
  endtask

  task automatic test_bypass();
    set_wb(1'b1, 1'b1, 64'h5555, 64'h1234, 5'd7);
    rs1 = 5'd7;
    rs2 = 5'd7;
    #1;
    checks++;
    if (rs1_data !== 64'h1234 || rs2_data !== 64'h1234) begin
      errors++; $display("FAIL bypass_both got=%h/%h exp=1234/1234", rs1_data, rs2_data);
    end
    rs2 = 5'd3;
    #1;
    checks++;
    if (rs2_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bypass_other_port got=%h exp=deadbeef", rs2_data); end
    step();
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 64'h1234) begin errors++; $display("FAIL bypass_committed got=%h exp=1234", rs1_data); end
    checks++;
    if (wr_count !== 32'd2) begin errors++; $display("FAIL bypass_wr_count got=%0d exp=2", wr_count); end
  endtask

  task automatic test_x0();
    set_wb(1'b0, 1'b1, 64'hFFFF, 64'h0, 5'd0);
    rs1 = 5'd0;
    #1;
    checks++;
    if (wb_en !== 1'b0) begin errors++; $display("FAIL x0_wb_en got=%0b exp=0", wb_en); end
    checks++;
    if (rs1_data !== 64'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", rs1_data); end
    step();
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 64'h0) begin errors++; $display("FAIL x0_after got=%h exp=0", rs1_data); end
    checks++;
    if (wr_count !== 32'd2) begin errors++; $display("FAIL x0_wr_count got=%0d exp=2", wr_count); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [4];
    vals[0] = 64'h0123_4567_89AB_CDEF;
    vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vals[2] = 64'h8000_0000_0000_0001;
    vals[3] = 64'h0000_0000_0000_00A5;
    for (int i = 0; i < 4; i++) begin
      set_wb(i[0], 1'b1, vals[i], vals[i], 5'(i + 10));
      step();
    end
    set_wb(1'b0, 1'b1, 64'h77, 64'h0, 5'd12);
    rs1 = 5'd12;
    rs2 = 5'd12;
    #1;
    checks++;
    if (rs1_data !== 64'h77) begin errors++; $display("FAIL b2b_overwrite_bypass got=%h exp=77", rs1_data); end
    step();
    RegWrite_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs1 = 5'(i + 10);
      #1;
      checks++;
      if (rs1_data !== ((i == 2) ? 64'h77 : vals[i])) begin
        errors++; $display("FAIL b2b_read_x%0d got=%h exp=%h", i + 10, rs1_data, (i == 2) ? 64'h77 : vals[i]);
      end
    end
    checks++;
    if (wr_count !== 32'd7) begin errors++; $display("FAIL b2b_wr_count got=%0d exp=7", wr_count); end
  endtask

  task automatic test_async_reset();
    set_wb(1'b0, 1'b1, 64'hAA, 64'h0, 5'd9);
    rs1 = 5'd9;
    step();
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 64'hAA) begin errors++; $display("FAIL areset_pre got=%h exp=aa", rs1_data); end
    set_wb(1'b0, 1'b1, 64'hBB, 64'h0, 5'd9);
    reset = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 64'h0) begin errors++; $display("FAIL areset_x9 got=%h exp=0", rs1_data); end
    checks++;
    if (wr_count !== 32'd0) begin errors++; $display("FAIL areset_wr_count got=%0d exp=0", wr_count); end
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (wr_count !== 32'd0) begin errors++; $display("FAIL areset_no_write_in_reset got=%0d exp=0", wr_count); end
    step();
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (rs1_data !== 64'hBB || wr_count !== 32'd1) begin
      errors++; $display("FAIL areset_first_commit got=%h cnt=%0d exp=bb cnt=1", rs1_data, wr_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 14; i++) begin
      set_wb(1'b0, 1'b1, 64'(i), 64'h0, 5'(i + 1));
      step();
    end
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (s_wr_count !== 4'd15) begin errors++; $display("FAIL wrap_pre got=%0d exp=15", s_wr_count); end
    set_wb(1'b0, 1'b1, 64'h1, 64'h0, 5'd20);
    step();
    RegWrite_in = 1'b0;
    #1;
    checks++;
    if (s_wr_count !== 4'd0) begin errors++; $display("FAIL wrap_zero got=%0d exp=0", s_wr_count); end
    checks++;
    if (wr_count !== 32'd16) begin errors++; $display("FAIL wrap_wide_count got=%0d exp=16", wr_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    set_wb(1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    rs1 = 5'd0;
    rs2 = 5'd0;
    test_reset();
    test_write_alu();
    test_bypass();
    test_x0();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
